// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response sequencer: default widths,
// timeout budget and the sequencer state encoding.
package puf_pkg;

    localparam int CNT_W_DEF   = 22;
    localparam int TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_COMPARE,
        S_DONE
    } state_t;

endpackage

// File: rtl/puf_pair_compare.sv
// Combinational comparison of one oscillator pair: response bit is A faster
// than B, and the bit is flagged stable when the counts differ by MARGIN or more.
module puf_pair_compare #(
    parameter int CNT_W  = 22,
    parameter int MARGIN = 8
) (
    input  logic [CNT_W-1:0] count_a,
    input  logic [CNT_W-1:0] count_b,
    output logic             bit_val,
    output logic             stable
);

    localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(MARGIN);

    logic             a_gt_b;
    logic [CNT_W-1:0] diff;

    // Subtract the smaller from the larger so the distance never wraps.
    always_comb begin
        a_gt_b  = count_a > count_b;
        diff    = a_gt_b ? (count_a - count_b) : (count_b - count_a);
        bit_val = a_gt_b;
        stable  = diff >= MARGIN_C;
    end

endmodule

// File: rtl/puf_response_sequencer.sv
// Steps through RESP_W challenges, runs both ring-oscillator counters for one
// window per challenge, and assembles the response word plus stability mask.
module puf_response_sequencer
    import puf_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int RESP_W  = 16,
    parameter int CHAL_W  = 4,
    parameter int MARGIN  = 8,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  count_a,
    input  logic [CNT_W-1:0]  count_b,
    input  logic              finished_a,
    input  logic              finished_b,
    output logic [CHAL_W-1:0] challenge,
    output logic              cnt_enable,
    output logic              cnt_reset,
    output logic [RESP_W-1:0] resp_data,
    output logic [RESP_W-1:0] resp_mask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              busy,
    output logic              error
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t            state, state_nx;
    logic [CHAL_W-1:0] index;
    logic              fin_a_q, fin_b_q;
    logic [TMR_W-1:0]  tmr;
    logic              both_fin, timed_out, last_bit;
    logic              cmp_bit, cmp_stable;

    puf_pair_compare #(
        .CNT_W  (CNT_W),
        .MARGIN (MARGIN)
    ) u_cmp (
        .count_a (count_a),
        .count_b (count_b),
        .bit_val (cmp_bit),
        .stable  (cmp_stable)
    );

    // A pulse on either finished line counts even if the other arrives later.
    assign both_fin  = (fin_a_q | finished_a) & (fin_b_q | finished_b);
    assign timed_out = tmr == TMR_W'(TIMEOUT - 1);
    assign last_bit  = index == CHAL_W'(RESP_W - 1);
    assign challenge = index;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nx   = state;
        cnt_reset  = 1'b0;
        cnt_enable = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                cnt_reset = 1'b1;
                busy      = 1'b0;
                if (start) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_reset = 1'b1;
                state_nx  = S_RUN;
            end
            S_RUN: begin
                cnt_enable = 1'b1;
                if (both_fin)       state_nx = S_COMPARE;
                else if (timed_out) state_nx = S_IDLE;
            end
            S_COMPARE: begin
                state_nx = last_bit ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                cnt_reset  = 1'b1;
                resp_valid = 1'b1;
                if (resp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only, so every
    // branch below sees the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            index     <= '0;
            fin_a_q   <= 1'b0;
            fin_b_q   <= 1'b0;
            tmr       <= '0;
            resp_data <= '0;
            resp_mask <= '0;
            error     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        index     <= '0;
                        error     <= 1'b0;
                        resp_data <= '0;
                        resp_mask <= '0;
                    end
                end
                S_CLEAR: begin
                    fin_a_q <= 1'b0;
                    fin_b_q <= 1'b0;
                    tmr     <= '0;
                end
                S_RUN: begin
                    fin_a_q <= fin_a_q | finished_a;
                    fin_b_q <= fin_b_q | finished_b;
                    tmr     <= tmr + TMR_W'(1);
                    if (!both_fin && timed_out) begin
                        error <= 1'b1;
                        index <= '0;
                    end
                end
                S_COMPARE: begin
                    resp_data[index] <= cmp_bit;
                    resp_mask[index] <= cmp_stable;
                    if (!last_bit) index <= index + CHAL_W'(1);
                end
                S_DONE: begin
                    if (resp_ready) index <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_response_sequencer.sv
// Self-checking bench: a behavioural counter-pair model drives the sequencer,
// and a response model computes expected words from the raw count tables.
module tb_puf_response_sequencer;

    localparam int CNT_W  = 22;
    localparam int RESP_W = 16;
    localparam int CHAL_W = 4;
    localparam int MARGIN = 8;
    localparam int TMO    = 4096;

    logic              clk, reset, start;
    logic [CNT_W-1:0]  count_a, count_b;
    logic              finished_a, finished_b;
    logic [CHAL_W-1:0] challenge;
    logic              cnt_enable, cnt_reset;
    logic [RESP_W-1:0] resp_data, resp_mask;
    logic              resp_valid, resp_ready, busy, error;

    puf_response_sequencer #(
        .CNT_W(CNT_W), .RESP_W(RESP_W), .CHAL_W(CHAL_W), .MARGIN(MARGIN), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .count_a(count_a), .count_b(count_b),
        .finished_a(finished_a), .finished_b(finished_b),
        .challenge(challenge), .cnt_enable(cnt_enable), .cnt_reset(cnt_reset),
        .resp_data(resp_data), .resp_mask(resp_mask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .busy(busy), .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counter-pair model state
    logic [CNT_W-1:0] ca [RESP_W];
    logic [CNT_W-1:0] cb [RESP_W];
    int  win_a = 1, win_b = 1, en_cnt = 0;
    bit  pulse_a = 1'b0, never_b = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [CNT_W-1:0]  ae, be, ao, bo;
        int                wa, wb;
        bit                pa;
        logic [RESP_W-1:0] xd, xm;
    } vec_t;

    vec_t vecs [7];

    // Counters: cleared by cnt_reset, advance one per enabled cycle, signal
    // completion after their window; counts depend on the selected challenge.
    initial begin
        finished_a = 1'b0;
        finished_b = 1'b0;
        count_a    = '0;
        count_b    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cnt_reset === 1'b1)       en_cnt = 0;
            else if (cnt_enable === 1'b1) en_cnt++;
            finished_a = pulse_a ? (en_cnt == win_a) : (en_cnt >= win_a);
            finished_b = !never_b && (en_cnt >= win_b);
            count_a    = ca[challenge];
            count_b    = cb[challenge];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_resp(output logic [RESP_W-1:0] d, output logic [RESP_W-1:0] m);
        longint a, b;
        for (int i = 0; i < RESP_W; i++) begin
            a    = longint'(ca[i]);
            b    = longint'(cb[i]);
            d[i] = a > b;
            m[i] = ((a > b) ? a - b : b - a) >= MARGIN;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then count cycles until resp_valid (0 = first CLEAR cycle).
    task automatic do_request(input int wa, input int wb, input bit pa, output int lat);
        win_a   = wa;
        win_b   = wb;
        pulse_a = pa;
        start   = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (resp_valid !== 1'b1 && lat < 20000) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_and_release(input string tag, input logic [RESP_W-1:0] xd,
                                      input logic [RESP_W-1:0] xm);
        check({tag, " data"}, 32'(resp_data), 32'(xd));
        check({tag, " mask"}, 32'(resp_mask), 32'(xm));
        for (int k = 0; k < 3; k++) begin
            tick();
            check({tag, " valid hold"}, 32'(resp_valid), 32'd1);
        end
        check({tag, " data hold"}, 32'(resp_data), 32'(xd));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, " valid drop"}, 32'(resp_valid), 32'd0);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    initial begin
        int lat, n, wa, wb;
        bit seen_valid;
        logic [RESP_W-1:0] xd, xm;
        logic [CNT_W-1:0] base, delta;

        for (int i = 0; i < RESP_W; i++) begin
            ca[i] = '0;
            cb[i] = '0;
        end
        resp_ready = 1'b0;

        // Reset held one cycle with start asserted: must stay idle
        reset = 1'b1;
        start = 1'b1;
        tick();
        check("rst cnt_reset", 32'(cnt_reset), 32'd1);
        check("rst cnt_enable", 32'(cnt_enable), 32'd0);
        check("rst challenge", 32'(challenge), 32'd0);
        check("rst resp_data", 32'(resp_data), 32'd0);
        check("rst resp_mask", 32'(resp_mask), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst error", 32'(error), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("post-rst busy", 32'(busy), 32'd0);

        // Directed vectors: {A/B even, A/B odd, windows, pulse mode, expected}
        vecs[0] = '{22'd500,  22'd480,  22'd500,  22'd480,  100, 100, 1'b0, 16'hFFFF, 16'hFFFF};
        vecs[1] = '{22'd300,  22'd303,  22'd303,  22'd300,  4,   4,   1'b0, 16'hAAAA, 16'h0000};
        vecs[2] = '{22'd1000, 22'd1000, 22'd1000, 22'd1000, 3,   8,   1'b1, 16'h0000, 16'h0000};
        vecs[3] = '{22'd508,  22'd500,  22'd508,  22'd500,  2,   1,   1'b0, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{22'd500,  22'd507,  22'd507,  22'd500,  1,   2,   1'b0, 16'hAAAA, 16'h0000};
        vecs[5] = '{22'd500,  22'd508,  22'd500,  22'd508,  3,   3,   1'b0, 16'h0000, 16'hFFFF};
        vecs[6] = '{22'h3FFFFF, 22'd0,  22'd0, 22'h3FFFFF,  2,   5,   1'b1, 16'h5555, 16'hFFFF};

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < RESP_W; i++) begin
                ca[i] = (i % 2 == 0) ? vecs[v].ae : vecs[v].ao;
                cb[i] = (i % 2 == 0) ? vecs[v].be : vecs[v].bo;
            end
            do_request(vecs[v].wa, vecs[v].wb, vecs[v].pa, lat);
            check($sformatf("vec%0d latency", v), 32'(lat),
                  32'(RESP_W * (max2(vecs[v].wa, vecs[v].wb) + 2)));
            finish_and_release($sformatf("vec%0d", v), vecs[v].xd, vecs[v].xm);
        end
        pulse_a = 1'b0;

        // start and resp_ready while busy and not valid are both ignored
        for (int i = 0; i < RESP_W; i++) begin
            ca[i] = CNT_W'(200 + i * 20);
            cb[i] = CNT_W'(400 - i * 20);
        end
        ref_resp(xd, xm);
        win_a = 5;
        win_b = 5;
        start = 1'b1;
        tick();
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            start      = (k < 10);
            resp_ready = (k >= 10);
            tick();
            lat++;
        end
        start      = 1'b0;
        resp_ready = 1'b0;
        while (resp_valid !== 1'b1 && lat < 20000) begin
            tick();
            lat++;
        end
        check("ignore latency", 32'(lat), 32'(RESP_W * 7));
        finish_and_release("ignore", xd, xm);

        // Randomised count tables against the response model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < RESP_W; i++) begin
                base  = CNT_W'($urandom_range(0, 4000));
                delta = CNT_W'($urandom_range(0, 16));
                ca[i] = base;
                cb[i] = $urandom_range(0, 1) ? base + delta : base - delta;
            end
            ref_resp(xd, xm);
            wa = $urandom_range(1, 12);
            wb = $urandom_range(1, 12);
            do_request(wa, wb, 1'($urandom_range(0, 1)), lat);
            check($sformatf("rnd%0d latency", r), 32'(lat), 32'(RESP_W * (max2(wa, wb) + 2)));
            finish_and_release($sformatf("rnd%0d", r), xd, xm);
        end
        pulse_a = 1'b0;

        // Timeout: finished_b never arrives
        never_b = 1'b1;
        win_a   = 3;
        start   = 1'b1;
        tick();
        start      = 1'b0;
        n          = 0;
        seen_valid = 1'b0;
        while (busy === 1'b1 && n < 6000) begin
            tick();
            n++;
            if (resp_valid === 1'b1) seen_valid = 1'b1;
        end
        check("timeout cycles", 32'(n), 32'(TMO + 1));
        check("timeout error", 32'(error), 32'd1);
        check("timeout no valid", 32'(seen_valid), 32'd0);
        tick();
        check("error sticky", 32'(error), 32'd1);
        never_b = 1'b0;

        // Next start clears error; reset during RUN of challenge 7
        win_a = 10;
        win_b = 10;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("error cleared", 32'(error), 32'd0);
        n = 0;
        while (!(challenge == CHAL_W'(7) && cnt_enable === 1'b1) && n < 2000) begin
            tick();
            n++;
        end
        check("reached chal7 run", 32'(n < 2000), 32'd1);
        check("partial data nonzero", 32'(resp_data != '0), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrun busy", 32'(busy), 32'd0);
        check("midrun cnt_reset", 32'(cnt_reset), 32'd1);
        check("midrun cnt_enable", 32'(cnt_enable), 32'd0);
        check("midrun challenge", 32'(challenge), 32'd0);
        check("midrun resp_data", 32'(resp_data), 32'd0);
        check("midrun resp_mask", 32'(resp_mask), 32'd0);
        check("midrun resp_valid", 32'(resp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
